// File: rtl/xyolo_write_seq.sv
// xyolo_write_seq
//   Sequencer for the YOLO write stage. Each accepted run walks n_out output
//   pixels of n_taps kernel taps each, issuing one tap per cycle. It drives
//   the pixel fetch port, the xyolo load strobes and the vwrite result port.
//
// State table
//   state | meaning
//   IDLE  | after reset, waiting for run
//   ISSUE | one tap fetch issued per cycle
//   DRAIN | fetches done, waiting for the delay pipeline to empty
//   DONE  | run complete, done held high until the next accepted run
//
// Ports
//   clk, rst (async, active low)
//   run                 start pulse, sampled in IDLE and DONE only
//   n_taps, n_out       taps per output, outputs per run
//   rd_base, tap_incr, out_incr   pixel address generation
//   wr_base, maxpool, lane_mask   result write control
//   vread_enB, vread_addrB        pixel fetch
//   ld_acc, ld_mp, ld_res         xyolo load strobes
//   vwrite_enB, vwrite_addrB      result write
//   busy, done                    status
module xyolo_write_seq #(
    parameter int ADDR_W  = 10,
    parameter int WADDR_W = 10,
    parameter int NVECT   = 16,
    parameter int CNT_W   = 10,
    parameter int RES_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic [CNT_W-1:0]   n_taps,
    input  logic [CNT_W-1:0]   n_out,
    input  logic [ADDR_W-1:0]  rd_base,
    input  logic [ADDR_W-1:0]  tap_incr,
    input  logic [ADDR_W-1:0]  out_incr,
    input  logic [WADDR_W-1:0] wr_base,
    input  logic               maxpool,
    input  logic [NVECT-1:0]   lane_mask,
    output logic               vread_enB,
    output logic [ADDR_W-1:0]  vread_addrB,
    output logic               ld_acc,
    output logic               ld_mp,
    output logic               ld_res,
    output logic [NVECT-1:0]   vwrite_enB,
    output logic [WADDR_W-1:0] vwrite_addrB,
    output logic               busy,
    output logic               done
);

    // Delay stages between the fetch register and the write register.
    localparam int PIPE_D = RES_LAT + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    logic               done_first;

    logic [CNT_W-1:0]   n_taps_r;
    logic [ADDR_W-1:0]  tap_incr_r;
    logic [ADDR_W-1:0]  out_incr_r;
    logic               maxpool_r;
    logic [NVECT-1:0]   lane_mask_r;

    // Down-counters: taps left after the current one, outputs left after the
    // current one. Terminal count is zero.
    logic [CNT_W-1:0]   tap_rem;
    logic [CNT_W-1:0]   out_rem;
    logic [1:0]         grp;
    logic [ADDR_W-1:0]  out_base;

    // Attributes of the tap currently on the fetch port.
    logic               cur_last;
    logic               cur_wr;
    logic [WADDR_W-1:0] cur_waddr;

    logic               s_v;
    logic [PIPE_D-1:0]  s_last;
    logic [PIPE_D-1:0]  s_wr;
    logic [WADDR_W-1:0] s_waddr [PIPE_D];

    logic               run_ok;
    logic               cfg_zero;

    always_comb begin
        run_ok   = 1'b0;
        cfg_zero = (n_taps == '0) || (n_out == '0);
        if (run) begin
            if (state == IDLE)
                run_ok = 1'b1;
            else if (state == DONE && !done_first)
                run_ok = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            done_first   <= 1'b0;
            n_taps_r     <= '0;
            tap_incr_r   <= '0;
            out_incr_r   <= '0;
            maxpool_r    <= 1'b0;
            lane_mask_r  <= '0;
            tap_rem      <= '0;
            out_rem      <= '0;
            grp          <= '0;
            out_base     <= '0;
            cur_last     <= 1'b0;
            cur_wr       <= 1'b0;
            cur_waddr    <= '0;
            s_v          <= 1'b0;
            s_last       <= '0;
            s_wr         <= '0;
            for (int k = 0; k < PIPE_D; k++)
                s_waddr[k] <= '0;
            vread_enB    <= 1'b0;
            vread_addrB  <= '0;
            ld_acc       <= 1'b0;
            ld_mp        <= 1'b0;
            ld_res       <= 1'b0;
            vwrite_enB   <= '0;
            vwrite_addrB <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            // Delay pipeline: fetch at c, ld_acc at c+2, ld_res at c+3,
            // write at c+3+RES_LAT.
            s_v        <= vread_enB;
            s_last     <= {s_last[PIPE_D-2:0], vread_enB & cur_last};
            s_wr       <= {s_wr[PIPE_D-2:0], vread_enB & cur_wr};
            s_waddr[0] <= cur_waddr;
            for (int k = 1; k < PIPE_D; k++)
                s_waddr[k] <= s_waddr[k-1];

            ld_acc       <= s_v;
            ld_res       <= s_last[1];
            ld_mp        <= s_last[1] & maxpool_r;
            vwrite_enB   <= s_wr[PIPE_D-1] ? lane_mask_r : '0;
            vwrite_addrB <= s_wr[PIPE_D-1] ? s_waddr[PIPE_D-1] : '0;

            done_first <= 1'b0;

            case (state)
                IDLE, DONE: begin
                    if (run_ok) begin
                        if (cfg_zero) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            done_first <= 1'b1;
                            busy       <= 1'b0;
                        end else begin
                            state       <= ISSUE;
                            busy        <= 1'b1;
                            done        <= 1'b0;
                            n_taps_r    <= n_taps;
                            tap_incr_r  <= tap_incr;
                            out_incr_r  <= out_incr;
                            maxpool_r   <= maxpool;
                            lane_mask_r <= lane_mask;
                            tap_rem     <= n_taps - CNT_W'(1);
                            out_rem     <= n_out - CNT_W'(1);
                            grp         <= 2'd0;
                            out_base    <= rd_base;
                            vread_enB   <= 1'b1;
                            vread_addrB <= rd_base;
                            cur_last    <= (n_taps == CNT_W'(1));
                            // Output 0 is only stored under maxpool when it
                            // is also the final output.
                            cur_wr      <= (n_taps == CNT_W'(1)) &&
                                           (!maxpool || n_out == CNT_W'(1));
                            cur_waddr   <= wr_base;
                        end
                    end
                end

                ISSUE: begin
                    if (tap_rem != '0) begin
                        tap_rem     <= tap_rem - CNT_W'(1);
                        vread_addrB <= vread_addrB + tap_incr_r;
                        cur_last    <= (tap_rem == CNT_W'(1));
                        cur_wr      <= (tap_rem == CNT_W'(1)) &&
                                       (!maxpool_r || grp == 2'd3 ||
                                        out_rem == '0);
                    end else if (out_rem != '0) begin
                        // Next output: grp and out_rem advance, so look at
                        // their upcoming values when deciding the write.
                        out_rem     <= out_rem - CNT_W'(1);
                        grp         <= grp + 2'd1;
                        tap_rem     <= n_taps_r - CNT_W'(1);
                        out_base    <= out_base + out_incr_r;
                        vread_addrB <= out_base + out_incr_r;
                        cur_last    <= (n_taps_r == CNT_W'(1));
                        cur_wr      <= (n_taps_r == CNT_W'(1)) &&
                                       (!maxpool_r || grp == 2'd2 ||
                                        out_rem == CNT_W'(1));
                        if (cur_wr)
                            cur_waddr <= cur_waddr + WADDR_W'(1);
                    end else begin
                        state       <= DRAIN;
                        vread_enB   <= 1'b0;
                        vread_addrB <= '0;
                        cur_last    <= 1'b0;
                        cur_wr      <= 1'b0;
                    end
                end

                DRAIN: begin
                    // The final output's last-tap flag leaves the pipeline
                    // in the same cycle its write is presented.
                    if (s_last == '0) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        done_first <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
